// File: rtl/chb_pkg.sv
// Shared types and helpers for the channel-buffer write side.
// No logic of its own: typedefs, constants and pure functions.
// Nothing here sees or applies backpressure.
package chb_pkg;

  localparam int NUM_BANKS = 3;

  typedef logic [1:0] sym_t;
  typedef logic [1:0] bank_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STALL
  } chb_wr_state_e;

  // Round-robin bank order 0 -> 1 -> 2 -> 0; value 3 is never produced.
  function automatic bank_t next_bank(input bank_t b);
    next_bank = (b == 2'd2) ? 2'd0 : b + 2'd1;
  endfunction

  // One-hot select vector for a bank index.
  function automatic logic [NUM_BANKS-1:0] bank_onehot(input bank_t b);
    bank_onehot = 3'b001 << b;
  endfunction

endpackage

// File: rtl/chb_writer_if.sv
// Symbol input, RAM write port and bank-status bundle of the buffer writer.
// No latency: plain wires between the writer and its neighbours.
// u_k_valid/u_k_ready handshake upstream; bank_release credit from the reader.
interface chb_writer_if #(
  parameter int ADDR_W = 6
);
  import chb_pkg::*;

  logic              en;
  sym_t              u_k;
  logic              u_k_valid;
  logic              u_k_ready;
  logic              bank_release;
  sym_t              wr_data;
  logic [ADDR_W-1:0] wr_addr;
  logic              writeRAM1;
  logic              writeRAM2;
  logic              writeRAM3;
  logic              readRAM1;
  logic              readRAM2;
  logic              readRAM3;
  logic              blk_done;

  // Writer side.
  modport slave (
    input  en, u_k, u_k_valid, bank_release,
    output u_k_ready, wr_data, wr_addr, writeRAM1, writeRAM2, writeRAM3,
           readRAM1, readRAM2, readRAM3, blk_done
  );

  // Environment side: symbol source plus reader.
  modport master (
    output en, u_k, u_k_valid, bank_release,
    input  u_k_ready, wr_data, wr_addr, writeRAM1, writeRAM2, writeRAM3,
           readRAM1, readRAM2, readRAM3, blk_done
  );

endinterface

// File: rtl/chb_bank_tracker.sv
// Tracks which banks hold a complete block and which one the reader owns.
// Set lands one edge after blk_done; release drops readRAMx on the next cycle.
// bank_release is ignored while en is low or when the read bank is empty.
module chb_bank_tracker
  import chb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 bank_release,
  input  logic [NUM_BANKS-1:0] set_i,
  output logic [NUM_BANKS-1:0] full_o,
  output logic [NUM_BANKS-1:0] clr_o,
  output logic [NUM_BANKS-1:0] read_o
);

  logic [NUM_BANKS-1:0] full_q, full_d;
  bank_t                rd_bank_q, rd_bank_d;
  logic                 rel_fire;

  // Release only counts when the oldest bank is actually full; set and clear
  // never collide because a full write bank forces the writer to stall.
  always_comb begin
    rel_fire  = en & bank_release & full_q[rd_bank_q];
    clr_o     = rel_fire ? bank_onehot(rd_bank_q) : '0;
    full_d    = (full_q & ~clr_o) | set_i;
    rd_bank_d = rel_fire ? next_bank(rd_bank_q) : rd_bank_q;
    read_o    = full_q[rd_bank_q] ? bank_onehot(rd_bank_q) : '0;
  end

  // Full flags and read pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q    <= '0;
      rd_bank_q <= '0;
    end else begin
      full_q    <= full_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  assign full_o = full_q;

endmodule

// File: rtl/chb_writer.sv
// Fills three RAM banks round-robin from a 2-bit symbol stream.
// Accepted symbol appears on the write port one cycle later; one symbol/cycle.
// u_k_ready drops while en is low or all three banks await the reader.
module chb_writer
  import chb_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  chb_writer_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  chb_wr_state_e        state_q, state_d;
  bank_t                wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0]    cnt_q, cnt_d;
  sym_t                 wr_data_q, wr_data_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [NUM_BANKS-1:0] strb_q, strb_d;
  logic                 blk_done_q, blk_done_d;

  logic [NUM_BANKS-1:0] full, clr, rd_onehot;
  logic                 ready, acc, last;
  bank_t                nb;

  // Reset gates ready so nothing is offered to the source while held.
  assign ready = bus.en & rst & (state_q != STALL);
  assign acc   = bus.u_k_valid & ready;
  assign last  = (cnt_q == LAST_ADDR);
  assign nb    = next_bank(wr_bank_q);

  // Next-state: write port, address counter, bank pointer and FSM.
  always_comb begin
    state_d    = state_q;
    wr_bank_d  = wr_bank_q;
    cnt_d      = cnt_q;
    wr_data_d  = wr_data_q;
    wr_addr_d  = wr_addr_q;
    strb_d     = '0;
    blk_done_d = 1'b0;
    if (acc) begin
      wr_data_d  = bus.u_k;
      wr_addr_d  = cnt_q;
      strb_d     = bank_onehot(wr_bank_q);
      blk_done_d = last;
      state_d    = FILL;
      if (last) begin
        cnt_d     = '0;
        wr_bank_d = nb;
        // A bank released on this very edge is free, so no stall for it.
        if (full[nb] & ~clr[nb]) state_d = STALL;
      end else begin
        cnt_d = cnt_q + ADDR_W'(1);
      end
    end
    // Leave STALL on the edge the blocking bank is freed; ready follows next cycle.
    if (state_q == STALL && clr[wr_bank_q]) state_d = FILL;
  end

  // Registered state and write-port outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_bank_q  <= '0;
      cnt_q      <= '0;
      wr_data_q  <= '0;
      wr_addr_q  <= '0;
      strb_q     <= '0;
      blk_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_bank_q  <= wr_bank_d;
      cnt_q      <= cnt_d;
      wr_data_q  <= wr_data_d;
      wr_addr_q  <= wr_addr_d;
      strb_q     <= strb_d;
      blk_done_q <= blk_done_d;
    end
  end

  // The final write and its full flag are one edge apart, so the reader
  // can never see a bank before its last symbol is in the RAM. The set is
  // applied even if en drops in between, so a completed block is never lost.
  chb_bank_tracker u_tracker (
    .clk          (clk),
    .rst          (rst),
    .en           (bus.en),
    .bank_release (bus.bank_release),
    .set_i        (strb_q & {NUM_BANKS{blk_done_q}}),
    .full_o       (full),
    .clr_o        (clr),
    .read_o       (rd_onehot)
  );

  assign bus.u_k_ready = ready;
  assign bus.wr_data   = wr_data_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.writeRAM1 = strb_q[0];
  assign bus.writeRAM2 = strb_q[1];
  assign bus.writeRAM3 = strb_q[2];
  assign bus.blk_done  = blk_done_q;
  assign bus.readRAM1  = rd_onehot[0];
  assign bus.readRAM2  = rd_onehot[1];
  assign bus.readRAM3  = rd_onehot[2];

endmodule

// File: tb/tb_chb_writer.sv
// Directed bench for chb_writer with DEPTH=4.
// Outputs are sampled 1ns after each rising edge; inputs change right after.
// Each scenario continues from the state left by the previous one.
module tb_chb_writer;

  logic clk;
  logic rst;
  int   vec_cnt;
  int   err_cnt;

  chb_writer_if #(.ADDR_W(2)) bif ();

  chb_writer #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  logic [2:0] wr_v;
  logic [2:0] rd_v;
  assign wr_v = {bif.writeRAM3, bif.writeRAM2, bif.writeRAM1};
  assign rd_v = {bif.readRAM3, bif.readRAM2, bif.readRAM1};

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bif.en = 1'b1;
    #12;
    vec_cnt++; if (wr_v !== 3'b000) begin err_cnt++; $display("FAIL rst_wstrb: got %b want 000", wr_v); end
    vec_cnt++; if (rd_v !== 3'b000) begin err_cnt++; $display("FAIL rst_read: got %b want 000", rd_v); end
    vec_cnt++; if (bif.wr_addr !== 2'd0 || bif.wr_data !== 2'd0) begin err_cnt++; $display("FAIL rst_port: got addr %0d data %0d want 0 0", bif.wr_addr, bif.wr_data); end
    vec_cnt++; if (bif.blk_done !== 1'b0) begin err_cnt++; $display("FAIL rst_done: got %b want 0", bif.blk_done); end
    vec_cnt++; if (bif.u_k_ready !== 1'b0) begin err_cnt++; $display("FAIL rst_ready: got %b want 0", bif.u_k_ready); end
    cyc();
    rst = 1'b1;
    #1;
    vec_cnt++; if (bif.u_k_ready !== 1'b1) begin err_cnt++; $display("FAIL idle_ready: got %b want 1", bif.u_k_ready); end
  endtask

  task automatic test_single_block();
    for (int i = 0; i < 4; i++) begin
      bif.u_k = 2'(i);
      bif.u_k_valid = 1'b1;
      cyc();
      vec_cnt++; if (wr_v !== 3'b001 || bif.wr_addr !== 2'(i) || bif.wr_data !== 2'(i)) begin
        err_cnt++; $display("FAIL blk1_write[%0d]: got strb %b addr %0d data %0d want 001 %0d %0d", i, wr_v, bif.wr_addr, bif.wr_data, i, i);
      end
      vec_cnt++; if (bif.blk_done !== (i == 3)) begin err_cnt++; $display("FAIL blk1_done[%0d]: got %b want %b", i, bif.blk_done, i == 3); end
      vec_cnt++; if (rd_v !== 3'b000) begin err_cnt++; $display("FAIL blk1_early_read[%0d]: got %b want 000", i, rd_v); end
    end
    bif.u_k_valid = 1'b0;
    cyc();
    vec_cnt++; if (rd_v !== 3'b001) begin err_cnt++; $display("FAIL blk1_read: got %b want 001", rd_v); end
    vec_cnt++; if (wr_v !== 3'b000 || bif.blk_done !== 1'b0) begin err_cnt++; $display("FAIL blk1_idle: got strb %b done %b want 000 0", wr_v, bif.blk_done); end
  endtask

  task automatic test_fill_stall();
    logic [2:0] exp_b;
    for (int j = 0; j < 8; j++) begin
      bif.u_k = 2'(j) ^ 2'b11;
      bif.u_k_valid = 1'b1;
      cyc();
      exp_b = (j < 4) ? 3'b010 : 3'b100;
      vec_cnt++; if (wr_v !== exp_b || bif.wr_addr !== 2'(j) || bif.wr_data !== (2'(j) ^ 2'b11)) begin
        err_cnt++; $display("FAIL fill_write[%0d]: got strb %b addr %0d data %0d want %b %0d %0d", j, wr_v, bif.wr_addr, bif.wr_data, exp_b, j & 3, (j & 3) ^ 3);
      end
      vec_cnt++; if (bif.u_k_ready !== (j != 7)) begin err_cnt++; $display("FAIL fill_ready[%0d]: got %b want %b", j, bif.u_k_ready, j != 7); end
    end
    bif.u_k = 2'b11;
    for (int k = 0; k < 2; k++) begin
      cyc();
      vec_cnt++; if (wr_v !== 3'b000 || bif.u_k_ready !== 1'b0) begin err_cnt++; $display("FAIL stall_hold[%0d]: got strb %b ready %b want 000 0", k, wr_v, bif.u_k_ready); end
      vec_cnt++; if (rd_v !== 3'b001) begin err_cnt++; $display("FAIL stall_read[%0d]: got %b want 001", k, rd_v); end
    end
    bif.u_k_valid = 1'b0;
  endtask

  task automatic test_release_resume();
    bif.bank_release = 1'b1;
    cyc();
    bif.bank_release = 1'b0;
    vec_cnt++; if (rd_v !== 3'b010) begin err_cnt++; $display("FAIL rel_read: got %b want 010", rd_v); end
    vec_cnt++; if (bif.u_k_ready !== 1'b1) begin err_cnt++; $display("FAIL rel_ready: got %b want 1", bif.u_k_ready); end
    bif.u_k = 2'b10;
    bif.u_k_valid = 1'b1;
    cyc();
    bif.u_k_valid = 1'b0;
    vec_cnt++; if (wr_v !== 3'b001 || bif.wr_addr !== 2'd0 || bif.wr_data !== 2'b10) begin
      err_cnt++; $display("FAIL resume_write: got strb %b addr %0d data %0d want 001 0 2", wr_v, bif.wr_addr, bif.wr_data);
    end
  endtask

  task automatic test_release_on_complete();
    for (int a = 1; a < 4; a++) begin
      bif.u_k = 2'(a);
      bif.u_k_valid = 1'b1;
      bif.bank_release = (a == 3);
      cyc();
      vec_cnt++; if (wr_v !== 3'b001 || bif.wr_addr !== 2'(a)) begin err_cnt++; $display("FAIL coll_write[%0d]: got strb %b addr %0d want 001 %0d", a, wr_v, bif.wr_addr, a); end
    end
    bif.bank_release = 1'b0;
    bif.u_k_valid = 1'b0;
    vec_cnt++; if (bif.blk_done !== 1'b1) begin err_cnt++; $display("FAIL coll_done: got %b want 1", bif.blk_done); end
    vec_cnt++; if (rd_v !== 3'b100) begin err_cnt++; $display("FAIL coll_read: got %b want 100", rd_v); end
    vec_cnt++; if (bif.u_k_ready !== 1'b1) begin err_cnt++; $display("FAIL coll_ready: got %b want 1", bif.u_k_ready); end
    cyc();
    vec_cnt++; if (rd_v !== 3'b100 || bif.u_k_ready !== 1'b1) begin err_cnt++; $display("FAIL coll_after: got read %b ready %b want 100 1", rd_v, bif.u_k_ready); end
  endtask

  task automatic test_enable();
    for (int a = 0; a < 2; a++) begin
      bif.u_k = 2'(a + 1);
      bif.u_k_valid = 1'b1;
      cyc();
      vec_cnt++; if (wr_v !== 3'b010 || bif.wr_addr !== 2'(a) || bif.wr_data !== 2'(a + 1)) begin
        err_cnt++; $display("FAIL en_pre[%0d]: got strb %b addr %0d data %0d want 010 %0d %0d", a, wr_v, bif.wr_addr, bif.wr_data, a, a + 1);
      end
    end
    bif.en = 1'b0;
    bif.u_k = 2'b11;
    bif.bank_release = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      vec_cnt++; if (wr_v !== 3'b000 || bif.u_k_ready !== 1'b0) begin err_cnt++; $display("FAIL en_off[%0d]: got strb %b ready %b want 000 0", k, wr_v, bif.u_k_ready); end
      vec_cnt++; if (bif.wr_addr !== 2'd1 || rd_v !== 3'b100) begin err_cnt++; $display("FAIL en_hold[%0d]: got addr %0d read %b want 1 100", k, bif.wr_addr, rd_v); end
    end
    bif.en = 1'b1;
    bif.bank_release = 1'b0;
    cyc();
    bif.u_k_valid = 1'b0;
    vec_cnt++; if (wr_v !== 3'b010 || bif.wr_addr !== 2'd2 || bif.wr_data !== 2'b11) begin
      err_cnt++; $display("FAIL en_resume: got strb %b addr %0d data %0d want 010 2 3", wr_v, bif.wr_addr, bif.wr_data);
    end
    vec_cnt++; if (rd_v !== 3'b100) begin err_cnt++; $display("FAIL en_read: got %b want 100", rd_v); end
  endtask

  task automatic test_reset_mid();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    for (int a = 0; a < 2; a++) begin
      bif.u_k = 2'(a + 2);
      bif.u_k_valid = 1'b1;
      cyc();
      vec_cnt++; if (wr_v !== 3'b001 || bif.wr_addr !== 2'(a)) begin err_cnt++; $display("FAIL mid_pre[%0d]: got strb %b addr %0d want 001 %0d", a, wr_v, bif.wr_addr, a); end
    end
    rst = 1'b0;
    #1;
    vec_cnt++; if (wr_v !== 3'b000 || rd_v !== 3'b000 || bif.blk_done !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_flags: got strb %b read %b done %b want 000 000 0", wr_v, rd_v, bif.blk_done); end
    vec_cnt++; if (bif.wr_addr !== 2'd0 || bif.wr_data !== 2'd0 || bif.u_k_ready !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_port: got addr %0d data %0d ready %b want 0 0 0", bif.wr_addr, bif.wr_data, bif.u_k_ready); end
    cyc();
    vec_cnt++; if (wr_v !== 3'b000) begin err_cnt++; $display("FAIL mid_rst_nostrb: got %b want 000", wr_v); end
    rst = 1'b1;
    bif.u_k_valid = 1'b0;
    bif.bank_release = 1'b1;
    cyc();
    bif.bank_release = 1'b0;
    vec_cnt++; if (rd_v !== 3'b000 || bif.u_k_ready !== 1'b1) begin err_cnt++; $display("FAIL empty_rel: got read %b ready %b want 000 1", rd_v, bif.u_k_ready); end
    for (int a = 0; a < 4; a++) begin
      bif.u_k = 2'(3 - a);
      bif.u_k_valid = 1'b1;
      cyc();
      vec_cnt++; if (wr_v !== 3'b001 || bif.wr_addr !== 2'(a) || bif.wr_data !== 2'(3 - a)) begin
        err_cnt++; $display("FAIL post_rst[%0d]: got strb %b addr %0d data %0d want 001 %0d %0d", a, wr_v, bif.wr_addr, bif.wr_data, a, 3 - a);
      end
    end
    bif.u_k_valid = 1'b0;
    cyc();
    vec_cnt++; if (rd_v !== 3'b001) begin err_cnt++; $display("FAIL post_rst_read: got %b want 001", rd_v); end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    vec_cnt = 0;
    err_cnt = 0;
    bif.en = 1'b0;
    bif.u_k = 2'b00;
    bif.u_k_valid = 1'b0;
    bif.bank_release = 1'b0;
    test_reset();
    test_single_block();
    test_fill_stall();
    test_release_resume();
    test_release_on_complete();
    test_enable();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
